// File: rtl/qpu_exu_alu_issue_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : qpu_exu_alu_issue_arb                                         |
// | Description : Round-robin issue arbiter for the shared ALU datapath (ALU,   |
// |               BJP, QIU) with a 1-entry registered result slot.              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module qpu_exu_alu_issue_arb #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_i_valid,
    output logic             alu_i_ready,
    input  logic [3:0]       alu_i_op,
    input  logic [XLEN-1:0]  alu_i_op1,
    input  logic [XLEN-1:0]  alu_i_op2,
    input  logic [TAG_W-1:0] alu_i_tag,
    input  logic             bjp_i_valid,
    output logic             bjp_i_ready,
    input  logic [3:0]       bjp_i_cmp,
    input  logic [XLEN-1:0]  bjp_i_op1,
    input  logic [XLEN-1:0]  bjp_i_op2,
    input  logic [TAG_W-1:0] bjp_i_tag,
    input  logic             qiu_i_valid,
    output logic             qiu_i_ready,
    input  logic [XLEN-1:0]  qiu_i_op1,
    input  logic [XLEN-1:0]  qiu_i_op2,
    input  logic [TAG_W-1:0] qiu_i_tag,
    output logic             dp_alu_req,
    output logic             dp_bjp_req,
    output logic             dp_qiu_req,
    output logic [7:0]       dp_op,
    output logic [XLEN-1:0]  dp_op1,
    output logic [XLEN-1:0]  dp_op2,
    input  logic [XLEN-1:0]  dp_res,
    input  logic             dp_cmp_res,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [1:0]       o_src,
    output logic [XLEN-1:0]  o_res,
    output logic             o_cmp,
    output logic [TAG_W-1:0] o_tag
);

    localparam logic [1:0] c_SRC_ALU = 2'b01;
    localparam logic [1:0] c_SRC_BJP = 2'b10;
    localparam logic [1:0] c_SRC_QIU = 2'b11;
    localparam logic [7:0] c_OP_ADD  = 8'b1000_0000;

    typedef enum logic [1:0] {
        PTR_ALU = 2'd0,
        PTR_BJP = 2'd1,
        PTR_QIU = 2'd2
    } ptr_e;

    ptr_e             ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [1:0]       src_q, src_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic             cmp_q, cmp_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             w_slot_free;
    logic [2:0]       w_gnt;

    assign w_slot_free = ~valid_q | o_ready;

    // Grant vector bit order is {QIU, BJP, ALU}; search starts at the pointer.
    always_comb begin
        w_gnt = 3'b000;
        if (!rst && w_slot_free) begin
            case (ptr_q)
                PTR_ALU: begin
                    if (alu_i_valid)      w_gnt = 3'b001;
                    else if (bjp_i_valid) w_gnt = 3'b010;
                    else if (qiu_i_valid) w_gnt = 3'b100;
                end
                PTR_BJP: begin
                    if (bjp_i_valid)      w_gnt = 3'b010;
                    else if (qiu_i_valid) w_gnt = 3'b100;
                    else if (alu_i_valid) w_gnt = 3'b001;
                end
                PTR_QIU: begin
                    if (qiu_i_valid)      w_gnt = 3'b100;
                    else if (alu_i_valid) w_gnt = 3'b001;
                    else if (bjp_i_valid) w_gnt = 3'b010;
                end
                default: w_gnt = 3'b000;
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        case (w_gnt)
            3'b001:  ptr_d = PTR_BJP;
            3'b010:  ptr_d = PTR_QIU;
            3'b100:  ptr_d = PTR_ALU;
            default: ptr_d = ptr_q;
        endcase
    end

    assign alu_i_ready = w_gnt[0];
    assign bjp_i_ready = w_gnt[1];
    assign qiu_i_ready = w_gnt[2];
    assign dp_alu_req  = w_gnt[0];
    assign dp_bjp_req  = w_gnt[1];
    assign dp_qiu_req  = w_gnt[2];

    always_comb begin
        dp_op  = 8'd0;
        dp_op1 = '0;
        dp_op2 = '0;
        case (w_gnt)
            3'b001: begin
                dp_op  = {alu_i_op, 4'b0000};
                dp_op1 = alu_i_op1;
                dp_op2 = alu_i_op2;
            end
            3'b010: begin
                dp_op  = {4'b0000, bjp_i_cmp};
                dp_op1 = bjp_i_op1;
                dp_op2 = bjp_i_op2;
            end
            3'b100: begin
                dp_op  = c_OP_ADD;
                dp_op1 = qiu_i_op1;
                dp_op2 = qiu_i_op2;
            end
            default: begin
                dp_op  = 8'd0;
                dp_op1 = '0;
                dp_op2 = '0;
            end
        endcase
    end

    // A new accept overwrites the slot even while it drains, keeping 1 op/cycle.
    always_comb begin
        valid_d = valid_q;
        src_d   = src_q;
        res_d   = res_q;
        cmp_d   = cmp_q;
        tag_d   = tag_q;
        if (|w_gnt) begin
            valid_d = 1'b1;
            if (w_gnt[1]) begin
                src_d = c_SRC_BJP;
                res_d = '0;
                cmp_d = dp_cmp_res;
                tag_d = bjp_i_tag;
            end else if (w_gnt[2]) begin
                src_d = c_SRC_QIU;
                res_d = dp_res;
                cmp_d = 1'b0;
                tag_d = qiu_i_tag;
            end else begin
                src_d = c_SRC_ALU;
                res_d = dp_res;
                cmp_d = 1'b0;
                tag_d = alu_i_tag;
            end
        end else if (o_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= PTR_ALU;
            valid_q <= 1'b0;
            src_q   <= 2'b00;
            res_q   <= '0;
            cmp_q   <= 1'b0;
            tag_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            res_q   <= res_d;
            cmp_q   <= cmp_d;
            tag_q   <= tag_d;
        end
    end

    assign o_valid = valid_q;
    assign o_src   = src_q;
    assign o_res   = res_q;
    assign o_cmp   = cmp_q;
    assign o_tag   = tag_q;

    a_alu_op_onehot: assert property (@(posedge clk) disable iff (rst)
        alu_i_valid |-> $onehot0(alu_i_op));
    a_bjp_cmp_onehot: assert property (@(posedge clk) disable iff (rst)
        bjp_i_valid |-> $onehot0(bjp_i_cmp));
    a_single_grant: assert property (@(posedge clk) $onehot0(w_gnt));

endmodule
`default_nettype wire
